instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 15'h0000, PC loaded on reset and used as the first fetch address.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  fetch enable; 0 holds the unit in IDLE.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  15  word address of the requested instruction.
REQ-007 mem_rvalid  input  1  read data valid, one-cycle pulse.
REQ-008 mem_rdata  input  16  instruction word returned by memory.
REQ-009 instr  output  16  held instruction, drives the decoder's full_instruction.
REQ-010 instr_valid  output  1  instr is valid and awaiting execution.
REQ-011 exec_ready  input  1  datapath retires instr this cycle.
REQ-012 branch  input  2  decoder control: 00 none, 01 branch, 10 jump, 11 treated as none.
REQ-013 pc_change  input  15  decoder PC offset; 1 for sequential, sign-extended offset for branches.
REQ-014 jump_target  input  16  register value used as the jump address; bits [14:0] used.
REQ-015 pc  output  15  address of the instruction currently held or being fetched.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH and ISSUE.
REQ-018 IDLE: mem_req=0 and instr_valid=0; run=1 moves to FETCH on the next edge.
REQ-019 FETCH: mem_req=1 and mem_addr=pc, held until mem_rvalid=1; then instr<=mem_rdata, go to ISSUE.
REQ-020 mem_rvalid outside FETCH SHALL be ignored with no state change.
REQ-021 ISSUE: instr_valid=1 and instr stable until exec_ready=1.
REQ-022 On the exec_ready edge, branch, pc_change and jump_target SHALL be sampled in the same cycle; the decoder path is combinational from instr.
REQ-023 Next PC: branch=01 gives pc+pc_change mod 2^15; branch=10 gives jump_target[14:0]; branch=00 or 11 gives pc+1 mod 2^15.
REQ-024 After retire: run=1 goes to FETCH; run=0 goes to IDLE with the updated pc retained.
REQ-025 Minimum throughput is 3 cycles per instruction (FETCH, rvalid, ISSUE/retire) with zero-wait memory and exec_ready already high.
REQ-026 Wrap-around: 0x7FFF+1 gives 0x0000, and a negative offset below 0 wraps modulo 2^15.
REQ-027 pc_change=0 SHALL be legal and refetch the same address (self-loop).
REQ-028 run deasserted during FETCH or ISSUE SHALL NOT abort the current instruction; the instruction completes first.
REQ-029 A retire and a run fall in the same cycle SHALL update pc and go to IDLE.

Reset
REQ-030 On rst_n=0, immediately: state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, mem_req=0, busy=0.
REQ-031 Reset mid-FETCH SHALL abandon the pending read, and a later stale mem_rvalid SHALL be ignored.
REQ-032 Release is synchronous to clk; the first fetch occurs no earlier than the first edge after release with run=1.

Configuration
REQ-033 Macro INSTR_FETCH_RETIRE_COUNT_EN SHALL control a retire-count feature.
REQ-034 With the macro defined: add output retire_count (32 bits), reset to 0, incremented on each retire and wrapping 0xFFFFFFFF to 0.
REQ-035 Without the macro: no port and no counter logic; all other behaviour is identical.

Structure
REQ-036 Shared package cpu_pkg SHALL hold the branch codes BR_NONE/BR_BRANCH/BR_JUMP, PC_W=15, INSTR_W=16 and the fetch state enum.
REQ-037 Sub-module pc_next (combinational: pc, branch, pc_change, jump_target -> next_pc) SHALL be instantiated once.

Verification
REQ-038 Reset, run=1, zero-wait memory returning 0x0000 at every address, exec_ready=1, branch=00, pc_change=1 -> mem_addr sequence 0,1,2, one instruction retired every 3 cycles.
REQ-039 pc=0x0010, branch=01, pc_change=0x7FFC (-4) -> next mem_addr=0x000C; pc=0x7FFF with branch=00 -> next mem_addr=0x0000.
REQ-040 branch=10, jump_target=0x8123 -> next mem_addr=0x0123; branch=11 -> pc+1.
REQ-041 mem_rvalid delayed 5 cycles, then exec_ready held low 4 cycles -> mem_req held and instr stable throughout; a spurious rvalid during ISSUE is ignored.
REQ-042 rst_n pulsed low mid-FETCH at pc=0x0040, stale rvalid after release -> pc=RESET_PC, state IDLE, instr unchanged at 0x0000.
REQ-043 Macro defined, 10 retires -> retire_count=10; counter preset to 0xFFFFFFFF plus one retire -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, decoder branch codes and the fetch FSM state encoding.
package cpu_pkg;

    localparam int PC_W    = 15;
    localparam int INSTR_W = 16;

    // Code 2'b11 is left out on purpose; every consumer treats it like BR_NONE.
    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_BRANCH = 2'b01,
        BR_JUMP   = 2'b10
    } branch_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, relative branch or absolute jump, all modulo 2^PC_W.
module pc_next
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]    pc_i,
    input  logic [1:0]         branch_i,
    input  logic [PC_W-1:0]    pc_change_i,
    input  logic [INSTR_W-1:0] jump_target_i,
    output logic [PC_W-1:0]    next_pc_o
);

    always_comb begin
        next_pc_o = pc_i + PC_W'(1);
        case (branch_i)
            BR_BRANCH: next_pc_o = pc_i + pc_change_i;
            BR_JUMP:   next_pc_o = jump_target_i[PC_W-1:0];
            default:   next_pc_o = pc_i + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> FETCH -> ISSUE loop holding one instruction for the datapath.
// Optional retire counter is enabled by defining INSTR_FETCH_RETIRE_COUNT_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 15'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_ready,
    input  logic [1:0]         branch,
    input  logic [PC_W-1:0]    pc_change,
    input  logic [INSTR_W-1:0] jump_target,
    output logic [PC_W-1:0]    pc,
    output logic               busy
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    ,
    output logic [31:0]        retire_count
`endif
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic               mem_req_q;
    logic               instr_valid_q;
    logic               busy_q;
    logic               retire;

    pc_next u_pc_next (
        .pc_i          (pc_q),
        .branch_i      (branch),
        .pc_change_i   (pc_change),
        .jump_target_i (jump_target),
        .next_pc_o     (pc_d)
    );

    assign retire = (state_q == ST_ISSUE) && exec_ready;

    // Outputs are registered alongside the state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q   <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_rvalid) begin
                        state_q       <= ST_ISSUE;
                        instr_q       <= mem_rdata;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // A late run drop still lets this instruction retire and move pc on.
                    if (exec_ready) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        if (run) begin
                            state_q   <= ST_FETCH;
                            mem_req_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;

`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_count = retire_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential/branch/jump addressing, stalls, run drop and reset abort.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_ready;
    logic [1:0]  branch;
    logic [14:0] pc_change;
    logic [15:0] jump_target;
    logic [14:0] pc;
    logic        busy;
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    int total = 0;
    int fails = 0;

    instr_fetch #(.RESET_PC(15'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .branch      (branch),
        .pc_change   (pc_change),
        .jump_target (jump_target),
        .pc          (pc),
        .busy        (busy)
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
        ,
        .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in FETCH; one wait cycle, rvalid, then retire: 3 cycles per instruction.
    task automatic do_instr(input logic [14:0] addr, input logic [15:0] data,
                            input logic [1:0] br, input logic [14:0] chg, input logic [15:0] jt);
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, addr);
        step();
        chk("wait_req", mem_req, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        chk("issue_valid", instr_valid, 1);
        chk("issue_instr", instr, data);
        chk("issue_noreq", mem_req, 0);
        branch      = br;
        pc_change   = chg;
        jump_target = jt;
        exec_ready  = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        exec_ready = 1'b1; branch = 2'b00; pc_change = 15'd1; jump_target = '0;
        #12;
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 15'h0000);
        chk("rst_instr", instr, 16'h0000);
        step();
        chk("rst_hold_busy", busy, 0);

        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);

        run = 1'b1;
        step();
        chk("start_busy", busy, 1);
        do_instr(15'h0000, 16'h0000, 2'b00, 15'd1, 16'h0000);
        do_instr(15'h0001, 16'h0000, 2'b00, 15'd1, 16'h0000);
        do_instr(15'h0002, 16'h0000, 2'b10, 15'd1, 16'h0010);
        do_instr(15'h0010, 16'hA001, 2'b01, 15'h7FFC, 16'h0000);
        do_instr(15'h000C, 16'hA002, 2'b10, 15'd1, 16'h8123);
        do_instr(15'h0123, 16'hA003, 2'b11, 15'd5, 16'h0000);
        do_instr(15'h0124, 16'hA004, 2'b10, 15'd1, 16'h7FFF);
        do_instr(15'h7FFF, 16'hA005, 2'b00, 15'd1, 16'h0000);
        do_instr(15'h0000, 16'hA006, 2'b01, 15'h7FFE, 16'h0000);
        do_instr(15'h7FFE, 16'hA007, 2'b01, 15'h0000, 16'h0000);

        // Slow memory and a stalled datapath at the self-looped address.
        exec_ready = 1'b0;
        chk("slow_addr", mem_addr, 15'h7FFE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("slow_req", mem_req, 1);
            chk("slow_addr_hold", mem_addr, 15'h7FFE);
            chk("slow_novalid", instr_valid, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'h1111;
            end
            step();
            mem_rvalid = 1'b0;
            chk("stall_instr", instr, 16'hBEEF);
            chk("stall_valid", instr_valid, 1);
            chk("stall_noreq", mem_req, 0);
        end

        // Retire and run drop together.
        run = 1'b0; exec_ready = 1'b1; branch = 2'b00; pc_change = 15'd1;
        step();
        chk("drop_busy", busy, 0);
        chk("drop_pc", pc, 15'h7FFF);
        chk("drop_valid", instr_valid, 0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_busy", busy, 0);
        chk("idle_rvalid_req", mem_req, 0);

        // Run dropped mid-FETCH still completes the instruction.
        run = 1'b1;
        step();
        chk("rf_req", mem_req, 1);
        chk("rf_addr", mem_addr, 15'h7FFF);
        run = 1'b0;
        step();
        chk("rf_hold_req", mem_req, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h2222;
        step();
        mem_rvalid = 1'b0;
        chk("rf_issue", instr, 16'h2222);
        step();
        chk("rf_idle_busy", busy, 0);
        chk("rf_wrap_pc", pc, 15'h0000);

        // Reset while fetching 0x0040, then a stale rvalid.
        run = 1'b1;
        step();
        do_instr(15'h0000, 16'h3333, 2'b10, 15'd1, 16'h0040);
        chk("pre_rst_addr", mem_addr, 15'h0040);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_pc", pc, 15'h0000);
        chk("arst_busy", busy, 0);
        chk("arst_instr", instr, 16'h0000);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5555;
        step();
        mem_rvalid = 1'b0;
        chk("stale_busy", busy, 0);
        chk("stale_instr", instr, 16'h0000);
        chk("stale_pc", pc, 15'h0000);
        run = 1'b1;
        chk("refetch_notyet", mem_req, 0);
        step();
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 15'h0000);

`ifdef INSTR_FETCH_RETIRE_COUNT_EN
        for (int i = 0; i < 10; i++) begin
            do_instr(15'(i), 16'(i), 2'b00, 15'd1, 16'h0000);
        end
        chk("retire_cnt10", retire_count, 32'd10);
        dut.retire_cnt_q = 32'hFFFF_FFFF;
        do_instr(15'd10, 16'h0000, 2'b00, 15'd1, 16'h0000);
        chk("retire_cnt_wrap", retire_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
